deadlock_axis_monitor: RTL and testbench

Parametrised per-level deadlock monitor for the co-simulation AXI-stream deadlock checker. It generalises the fixed per-instance monitors with any channel count, mask-selected channel ownership, any number of child monitors, and a persistence filter that rejects transient stalls. It adds a sticky flag, first-blocking-channel capture and a saturating event counter. Instances chain upward through `sub_block`/`block`, top level first.

---
 rtl/deadlock_axis_monitor_if.sv | 28 ++
 rtl/deadlock_axis_monitor.sv | 105 ++++++++++
 tb/tb_deadlock_axis_monitor.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/deadlock_axis_monitor_if.sv
// Signal bundle between a deadlock monitor and whatever drives and observes it.
// mon_state exposes the monitor's filter state (0 idle, 1 pending, 2 blocked).
interface deadlock_axis_monitor_if #(
  parameter int NUM_AXIS = 15,
  parameter int NUM_SUB  = 1,
  parameter int CNT_W    = 8,
  parameter int CH_W     = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
);
  logic [NUM_AXIS-1:0] axis_block_sigs;
  logic [NUM_SUB-1:0]  sub_block;
  logic                clear;
  logic                block;
  logic                block_sticky;
  logic                first_valid;
  logic [CH_W-1:0]     first_chan;
  logic [CNT_W-1:0]    block_events;
  logic [1:0]          mon_state;

  modport master (
    output axis_block_sigs, sub_block, clear,
    input  block, block_sticky, first_valid, first_chan, block_events, mon_state
  );

  modport slave (
    input  axis_block_sigs, sub_block, clear,
    output block, block_sticky, first_valid, first_chan, block_events, mon_state
  );
endinterface

// File: rtl/deadlock_axis_monitor.sv
// Per-level AXI-stream deadlock monitor: persistence-filtered block output plus
// sticky flag, first-blocking-channel capture and a saturating rise counter.
module deadlock_axis_monitor #(
  parameter int                  NUM_AXIS  = 15,
  parameter int                  NUM_SUB   = 1,
  parameter logic [NUM_AXIS-1:0] CUR_MASK  = 15'b11,
  parameter logic [NUM_AXIS-1:0] DESC_MASK = 15'h7FFC,
  parameter int                  THRESHOLD = 1,
  parameter int                  CNT_W     = 8,
  parameter int                  CH_W      = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
) (
  input logic                    clock,
  input logic                    reset,
  deadlock_axis_monitor_if.slave mon
);
  localparam int CNT_BITS = (THRESHOLD > 1) ? $clog2(THRESHOLD + 1) : 1;
  localparam logic [CNT_BITS-1:0] THR    = CNT_BITS'(THRESHOLD);
  localparam logic [CNT_BITS-1:0] THR_M1 = CNT_BITS'(THRESHOLD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [NUM_AXIS-1:0] cur_vec, desc_vec, raw_vec;
  logic                raw, rise;
  logic [CH_W-1:0]     low_idx;

  logic                sticky_q, first_valid_q;
  logic [CH_W-1:0]     first_chan_q;
  logic [CNT_W-1:0]    events_q;

  // Descendant-owned channels only count while some child is itself blocked.
  assign cur_vec  = mon.axis_block_sigs & CUR_MASK;
  assign desc_vec = (|mon.sub_block) ? (mon.axis_block_sigs & DESC_MASK) : '0;
  assign raw_vec  = cur_vec | desc_vec;
  assign raw      = |raw_vec;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!raw) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      if (cnt_q < THR) cnt_d = cnt_q + CNT_BITS'(1);
      state_d = (cnt_q >= THR_M1) ? BLOCKED : PENDING;
    end
  end

  assign rise = (state_q != BLOCKED) && (state_d == BLOCKED);

  always_comb begin
    low_idx = '0;
    for (int i = NUM_AXIS - 1; i >= 0; i--) begin
      if (raw_vec[i]) low_idx = CH_W'(i);
    end
  end

  // A rise in the same cycle as clear lands on top of the cleared state.
  always_ff @(posedge clock) begin
    if (reset) begin
      sticky_q      <= 1'b0;
      first_valid_q <= 1'b0;
      first_chan_q  <= '0;
      events_q      <= '0;
    end else begin
      if (mon.clear) begin
        sticky_q      <= 1'b0;
        first_valid_q <= 1'b0;
        first_chan_q  <= '0;
        events_q      <= '0;
      end
      if (rise) begin
        sticky_q <= 1'b1;
        if (mon.clear)          events_q <= CNT_W'(1);
        else if (events_q != '1) events_q <= events_q + CNT_W'(1);
        if (mon.clear || !first_valid_q) begin
          first_chan_q  <= low_idx;
          first_valid_q <= 1'b1;
        end
      end
    end
  end

  assign mon.block        = (state_q == BLOCKED);
  assign mon.block_sticky = sticky_q;
  assign mon.first_valid  = first_valid_q;
  assign mon.first_chan   = first_chan_q;
  assign mon.block_events = events_q;
  assign mon.mon_state    = state_q;
endmodule

// File: tb/tb_deadlock_axis_monitor.sv
// Bench for deadlock_axis_monitor: three instances (THRESHOLD 1/4, and a 2-bit
// event counter) share stimulus and are compared every cycle to a run-length model.
module tb_deadlock_axis_monitor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] axis = '0;
  logic        sub = 1'b0;
  logic        clr = 1'b0;
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  deadlock_axis_monitor_if #(.NUM_AXIS(15), .NUM_SUB(1), .CNT_W(8), .CH_W(4)) mif1 ();
  deadlock_axis_monitor_if #(.NUM_AXIS(15), .NUM_SUB(1), .CNT_W(8), .CH_W(4)) mif4 ();
  deadlock_axis_monitor_if #(.NUM_AXIS(15), .NUM_SUB(1), .CNT_W(2), .CH_W(4)) mifs ();

  assign mif1.axis_block_sigs = axis;
  assign mif1.sub_block       = sub;
  assign mif1.clear           = clr;
  assign mif4.axis_block_sigs = axis;
  assign mif4.sub_block       = sub;
  assign mif4.clear           = clr;
  assign mifs.axis_block_sigs = axis;
  assign mifs.sub_block       = sub;
  assign mifs.clear           = clr;

  deadlock_axis_monitor #(.NUM_AXIS(15), .NUM_SUB(1), .CUR_MASK(15'b11), .DESC_MASK(15'h7FFC),
    .THRESHOLD(1), .CNT_W(8), .CH_W(4)) u1 (.clock(clk), .reset(rst), .mon(mif1.slave));
  deadlock_axis_monitor #(.NUM_AXIS(15), .NUM_SUB(1), .CUR_MASK(15'b11), .DESC_MASK(15'h7FFC),
    .THRESHOLD(4), .CNT_W(8), .CH_W(4)) u4 (.clock(clk), .reset(rst), .mon(mif4.slave));
  deadlock_axis_monitor #(.NUM_AXIS(15), .NUM_SUB(1), .CUR_MASK(15'b11), .DESC_MASK(15'h7FFC),
    .THRESHOLD(1), .CNT_W(2), .CH_W(4)) us (.clock(clk), .reset(rst), .mon(mifs.slave));

  logic       o_block[3], o_sticky[3], o_fv[3];
  logic [3:0] o_fc[3];
  logic [7:0] o_ev[3];
  logic [1:0] o_st[3];

  assign o_block[0] = mif1.block;        assign o_block[1] = mif4.block;        assign o_block[2] = mifs.block;
  assign o_sticky[0] = mif1.block_sticky; assign o_sticky[1] = mif4.block_sticky; assign o_sticky[2] = mifs.block_sticky;
  assign o_fv[0] = mif1.first_valid;     assign o_fv[1] = mif4.first_valid;     assign o_fv[2] = mifs.first_valid;
  assign o_fc[0] = mif1.first_chan;      assign o_fc[1] = mif4.first_chan;      assign o_fc[2] = mifs.first_chan;
  assign o_ev[0] = mif1.block_events;    assign o_ev[1] = mif4.block_events;    assign o_ev[2] = {6'b0, mifs.block_events};
  assign o_st[0] = mif1.mon_state;       assign o_st[1] = mif4.mon_state;       assign o_st[2] = mifs.mon_state;

  // Behavioural model: length of the current run of blocking cycles decides block.
  int thr[3]   = '{1, 4, 1};
  int evmax[3] = '{255, 255, 3};
  int run[3]   = '{0, 0, 0};
  bit m_blk[3], m_sticky[3], m_fv[3];
  int m_fc[3], m_ev[3];

  always @(posedge clk) begin
    logic [14:0] rv;
    int          low;
    bit          found, nb;
    rv = (axis & 15'h0003) | (sub ? (axis & 15'h7FFC) : 15'h0000);
    found = 1'b0;
    low = 0;
    for (int i = 0; i < 15; i++) begin
      if (rv[i] && !found) begin
        low = i;
        found = 1'b1;
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        run[k] = 0; m_blk[k] = 0; m_sticky[k] = 0; m_fv[k] = 0; m_fc[k] = 0; m_ev[k] = 0;
      end else begin
        run[k] = (rv != 0) ? ((run[k] < 1000) ? run[k] + 1 : run[k]) : 0;
        nb = (run[k] >= thr[k]);
        if (clr) begin
          m_sticky[k] = 0; m_fv[k] = 0; m_fc[k] = 0; m_ev[k] = 0;
        end
        if (!m_blk[k] && nb) begin
          m_sticky[k] = 1;
          if (m_ev[k] < evmax[k]) m_ev[k] = m_ev[k] + 1;
          if (!m_fv[k]) begin
            m_fc[k] = low;
            m_fv[k] = 1;
          end
        end
        m_blk[k] = nb;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("dut%0d.block", k), 32'(o_block[k]), 32'(m_blk[k]));
        chk($sformatf("dut%0d.sticky", k), 32'(o_sticky[k]), 32'(m_sticky[k]));
        chk($sformatf("dut%0d.first_valid", k), 32'(o_fv[k]), 32'(m_fv[k]));
        chk($sformatf("dut%0d.first_chan", k), 32'(o_fc[k]), 32'(m_fc[k]));
        chk($sformatf("dut%0d.events", k), 32'(o_ev[k]), 32'(m_ev[k]));
        chk($sformatf("dut%0d.state", k), 32'(o_st[k]),
            m_blk[k] ? 32'd2 : (run[k] > 0 ? 32'd1 : 32'd0));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; axis = '0; sub = 1'b0; clr = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    do_reset();
    chk_en = 1'b1;
    chk("reset.block", 32'(o_block[1]), 0);
    chk("reset.events", 32'(o_ev[0]), 0);

    // THRESHOLD=1 single-cycle pulse on bit 0
    axis = 15'h0001; cyc();
    chk("t1.block", 32'(o_block[0]), 1);
    chk("t1.events", 32'(o_ev[0]), 1);
    chk("t1.first_chan", 32'(o_fc[0]), 0);
    axis = '0; cyc();
    chk("t1.block_drop", 32'(o_block[0]), 0);
    chk("t1.sticky", 32'(o_sticky[0]), 1);

    // THRESHOLD=4: transient burst rejected, persistent burst accepted
    do_reset();
    axis = 15'h0002; repeat (3) cyc();
    chk("t4.burst1", 32'(o_block[1]), 0);
    axis = '0; cyc();
    axis = 15'h0002; repeat (3) cyc();
    chk("t4.pre_rise", 32'(o_block[1]), 0);
    cyc();
    chk("t4.rise", 32'(o_block[1]), 1);
    repeat (2) cyc();
    chk("t4.held", 32'(o_block[1]), 1);
    axis = '0; cyc();
    chk("t4.fall", 32'(o_block[1]), 0);
    chk("t4.events", 32'(o_ev[1]), 1);

    // descendant gating
    do_reset();
    axis = 15'h0020; sub = 1'b0; repeat (3) cyc();
    chk("desc.gated", 32'(o_block[0]), 0);
    sub = 1'b1; cyc();
    chk("desc.block", 32'(o_block[0]), 1);
    chk("desc.first_chan", 32'(o_fc[0]), 5);
    do_reset();
    axis = 15'h0280; sub = 1'b1; cyc();
    chk("desc.lowest", 32'(o_fc[0]), 7);

    // saturation of the 2-bit event counter
    do_reset();
    for (int i = 0; i < 5; i++) begin
      axis = 15'h0001; cyc();
      axis = '0; cyc();
      chk($sformatf("sat.events%0d", i), 32'(o_ev[2]), sat_exp[i]);
    end

    // clear colliding with a rise on bit 12
    do_reset();
    axis = 15'h0001; cyc();
    axis = '0; cyc();
    chk("clr.prior_chan", 32'(o_fc[0]), 0);
    axis = 15'h1000; sub = 1'b1; clr = 1'b1; cyc();
    clr = 1'b0; axis = '0; sub = 1'b0;
    chk("clr.sticky", 32'(o_sticky[0]), 1);
    chk("clr.first_chan", 32'(o_fc[0]), 12);
    chk("clr.first_valid", 32'(o_fv[0]), 1);
    chk("clr.events", 32'(o_ev[0]), 1);

    // reset while blocked, THRESHOLD=4
    do_reset();
    axis = 15'h0001; repeat (5) cyc();
    chk("rstb.blocked", 32'(o_block[1]), 1);
    rst = 1'b1; cyc();
    rst = 1'b0;
    chk("rstb.block", 32'(o_block[1]), 0);
    chk("rstb.sticky", 32'(o_sticky[1]), 0);
    chk("rstb.events", 32'(o_ev[1]), 0);
    repeat (3) cyc();
    chk("rstb.pending", 32'(o_block[1]), 0);
    cyc();
    chk("rstb.reassert", 32'(o_block[1]), 1);

    // randomized traffic, checked by the model every cycle
    do_reset();
    repeat (600) begin
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 2))
          0: axis = '0;
          1: axis = 15'(1 << $urandom_range(0, 14));
          default: axis = 15'($urandom_range(0, 32767));
        endcase
      end
      sub = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0; clr = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
